uart_word_link: RTL and testbench
=================================

Name: uart_word_link

Overview:
- 8N1 UART transceiver that assembles four received bytes into a 32-bit word and serialises a 32-bit word as four bytes.
- Sits between a board UART pin pair and fabric logic.
- Connecting uart_rx_reg→uart_tx_reg and uart_rx_ready→uart_tx_en yields a word-level echo loopback.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- Derived constant BIT_CYC = CLK_FREQ/BAUD, integer division (5208 at defaults); HALF_CYC = BIT_CYC/2.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, idle high, asynchronous to sys_clk.
- uart_tx  out  1  serial output, idle high.
- uart_rx_reg  out  32  last completely received word.
- uart_rx_ready  out  1  one-cycle pulse: uart_rx_reg has just been updated.
- uart_tx_reg  in  32  word to transmit; sampled when uart_tx_en is accepted.
- uart_tx_en  in  1  transmit request, level-sampled each cycle.

Behaviour:
- Reset (async assert, sync release): uart_tx=1, uart_rx_reg=0, uart_rx_ready=0, byte counter=0, RX and TX FSMs IDLE.
- RX input: 2-flop synchroniser, then falling-edge detect.
- RX FSM states: IDLE → START → DATA → STOP.
  - IDLE: a synchronised falling edge enters START and clears the bit timer.
  - START: at HALF_CYC, sample the line. If it is 1, treat as a glitch and return to IDLE; if 0, go to DATA.
  - DATA: sample every BIT_CYC; 8 data bits, LSB first, shifted into a byte register.
  - STOP: sample one BIT_CYC later. If 1, the byte is valid; if 0 (framing error), discard the byte. In both cases return to IDLE; the byte counter is unchanged on error.
- Word assembly: each valid byte shifts in as word = {word[23:0], byte], so the first byte ends in [31:24].
  - Byte counter counts 0..3. On the 4th valid byte, uart_rx_reg is updated with the completed word and uart_rx_ready pulses high for exactly 1 cycle. Both happen on the clock after the stop-bit sample. The counter then wraps to 0.
  - uart_rx_reg holds its value until the next complete word.
  - No inter-byte timeout; the word boundary is defined only by the byte count since reset.
- RX can re-arm in IDLE during the stop-bit's second half, so back-to-back frames are received without loss.
- TX FSM states: IDLE → START → DATA → STOP → (next byte or IDLE).
  - In IDLE, uart_tx_en=1 latches uart_tx_reg and starts byte 0.
  - Byte order: [31:24], [23:16], [15:8], [7:0].
  - Each frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly BIT_CYC cycles.
  - The four frames are sent back-to-back with no idle gap. The FSM returns to IDLE after the 4th stop bit.
  - uart_tx_en while not IDLE is ignored; there is no queueing.
  - Latency: uart_tx falls to the start bit on the clock after uart_tx_en is accepted.
  - A full word takes 40*BIT_CYC cycles.
- uart_tx is driven from a register (glitch-free).
- RX and TX are independent and may run simultaneously.
- Reset mid-frame aborts both FSMs immediately. uart_tx goes to 1 and any partial word is lost.

Decomposition:
- Shared package: CLK_FREQ/BAUD defaults, BIT_CYC/HALF_CYC derivation function, RX/TX FSM state enums.
- One natural sub-module, uart_byte_rx: synchroniser, start detect, byte shift and valid/framing outputs.
- Word assembly and the TX FSM stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 200 ns → uart_tx=1, uart_rx_reg=0, uart_rx_ready=0 throughout.
- Four frames, back-to-back at BIT_CYC=5208, whose line bit sequences after the start bit are 0000000 1 / 0000001 0 / 0000001 1 / 0000010 0 (8 data bits, first bit on the line first, then stop=1):
  - bytes LSB-first are 0x80, 0x40, 0xC0, 0x20;
  - exactly one uart_rx_ready pulse, after the 4th stop-bit sample;
  - uart_rx_reg=0x8040C020.
- Loopback (rx_reg→tx_reg, rx_ready→tx_en) after the previous case → uart_tx emits 0x80, 0x40, 0xC0, 0x20 frames. Each bit lasts 5208±0 cycles; the first start edge comes 1 cycle after the ready pulse; there are no gaps.
- Glitch: uart_rx low for 100 cycles then high → no byte counted. A following 4-byte word 0x11,0x22,0x33,0x44 gives uart_rx_reg=0x11223344.
- Framing error: byte 0x55 with stop bit=0, then 4 good bytes A,B,C,D → bad byte dropped; word = {A,B,C,D} (counter unaffected).
- TX busy: pulse uart_tx_en with 0xDEADBEEF, then uart_tx_en with 0x12345678 mid-transmission → only DE AD BE EF is sent; the second request is ignored.

Source files
------------

// File: rtl/uart_word_link_pkg.sv
// rtl/uart_word_link_pkg.sv - shared line-rate constants and FSM encodings for uart_word_link
package uart_word_link_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 9600;

  // RX and TX walk the same four phases of an 8N1 frame
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_cycles(input int unsigned bit_cyc);
    return bit_cyc / 2;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 byte receiver: synchroniser, start detect, LSB-first shift, stop check
module uart_byte_rx #(
  parameter int unsigned BIT_CYC  = 5208,
  parameter int unsigned HALF_CYC = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid
);
  import uart_word_link_pkg::*;

  localparam int unsigned   TW        = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYC - 1);

  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          fall, tick_half, tick_bit;

  assign fall      = rx_prev & ~rx_sync;
  assign tick_half = (timer == HALF_LAST);
  assign tick_bit  = (timer == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_START;
            timer <= '0;
          end
        end
        ST_START: begin
          // a line back high at mid start bit was a glitch, not a frame
          if (tick_half) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_bit) begin
            timer   <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          // leaving at mid stop bit lets the next start edge be caught
          if (tick_bit) begin
            timer <= '0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

  assign byte_data  = shreg;
  assign byte_valid = (state == ST_STOP) && tick_bit && rx_sync;

endmodule

// File: rtl/uart_word_link.sv
// rtl/uart_word_link.sv - 8N1 UART moving 32-bit words as four MSB-byte-first frames
module uart_word_link #(
  parameter int unsigned CLK_FREQ = uart_word_link_pkg::DEF_CLK_FREQ,
  parameter int unsigned BAUD     = uart_word_link_pkg::DEF_BAUD
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [31:0] uart_rx_reg,
  output logic        uart_rx_ready,
  input  logic [31:0] uart_tx_reg,
  input  logic        uart_tx_en
);
  import uart_word_link_pkg::*;

  localparam int unsigned   BIT_CYC  = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned   HALF_CYC = half_cycles(BIT_CYC);
  localparam int unsigned   TW       = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYC - 1);

  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [1:0]  byte_cnt;
  logic [23:0] word_acc;

  uart_byte_rx #(
    .BIT_CYC  (BIT_CYC),
    .HALF_CYC (HALF_CYC)
  ) u_byte_rx (
    .clk        (sys_clk),
    .rst_n      (rst_n),
    .rx         (uart_rx),
    .byte_data  (rx_byte),
    .byte_valid (rx_byte_valid)
  );

  // framed-bad bytes never reach here, so the count only tracks good bytes
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt      <= '0;
      word_acc      <= '0;
      uart_rx_reg   <= '0;
      uart_rx_ready <= 1'b0;
    end else begin
      uart_rx_ready <= 1'b0;
      if (rx_byte_valid) begin
        if (byte_cnt == 2'd3) begin
          uart_rx_reg   <= {word_acc, rx_byte};
          uart_rx_ready <= 1'b1;
        end else begin
          word_acc <= {word_acc[15:0], rx_byte};
        end
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  logic [1:0]    tx_state;
  logic [TW-1:0] tx_timer;
  logic [2:0]    tx_bit;
  logic [1:0]    tx_byte;
  logic [7:0]    tx_shift;
  logic [23:0]   tx_rest;
  logic          tx_tick;

  assign tx_tick = (tx_timer == BIT_LAST);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= ST_IDLE;
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      tx_shift <= '0;
      tx_rest  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (uart_tx_en) begin
            tx_shift <= uart_tx_reg[31:24];
            tx_rest  <= uart_tx_reg[23:0];
            tx_byte  <= '0;
            tx_timer <= '0;
            uart_tx  <= 1'b0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_tick) begin
            tx_timer <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= ST_DATA;
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_tick) begin
            tx_timer <= '0;
            tx_bit   <= tx_bit + 1'b1;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              uart_tx  <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
        default: begin
          // next frame's start bit follows the stop bit with no idle gap
          if (tx_tick) begin
            tx_timer <= '0;
            if (tx_byte == 2'd3) begin
              tx_state <= ST_IDLE;
            end else begin
              tx_byte  <= tx_byte + 1'b1;
              tx_shift <= tx_rest[23:16];
              tx_rest  <= {tx_rest[15:0], 8'h00};
              uart_tx  <= 1'b0;
              tx_state <= ST_START;
            end
          end else begin
            tx_timer <= tx_timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_link.sv
// tb/tb_uart_word_link.sv - randomized self-checking bench for uart_word_link against a word-level model
module tb_uart_word_link;

  localparam int B = 16;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [31:0] uart_rx_reg;
  logic        uart_rx_ready;
  logic [31:0] uart_tx_reg;
  logic        uart_tx_en;

  logic        loop      = 1'b0;
  logic [31:0] tb_tx_reg = '0;
  logic        tb_tx_en  = 1'b0;
  logic        mon_on    = 1'b0;

  assign uart_tx_reg = loop ? uart_rx_reg   : tb_tx_reg;
  assign uart_tx_en  = loop ? uart_rx_ready : tb_tx_en;

  uart_word_link #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .uart_rx_reg   (uart_rx_reg),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_reg   (uart_tx_reg),
    .uart_tx_en    (uart_tx_en)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Receive model: the n-th good byte since reset lands in byte slot n mod 4.
  logic [31:0] rx_exp[$];
  logic [31:0] rx_last = '0;
  logic [7:0]  m_bytes[$];
  int          ready_pulses = 0;

  task automatic model_byte(input logic [7:0] b);
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      rx_exp.push_back({m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]});
      m_bytes.delete();
    end
  endtask

  // Transmit model: a request is honoured only when no word is in flight (40 bit times).
  int         busy = 0;
  logic [7:0] tx_exp[$];
  int         tx_start_exp[$];
  logic [7:0] tx_log[$];

  always @(negedge sys_clk) begin
    if (mon_on) begin
      if (uart_rx_ready === 1'b1) begin
        ready_pulses++;
        if (rx_exp.size() == 0) chk("rx_ready_unexpected", 32'(uart_rx_ready), 32'd0);
        else begin
          rx_last = rx_exp.pop_front();
          chk("rx_word", uart_rx_reg, rx_last);
        end
      end else begin
        chk("rx_reg_hold", uart_rx_reg, rx_last);
      end

      if (busy > 0) busy--;
      else if (uart_tx_en === 1'b1) begin
        for (int i = 3; i >= 0; i--) tx_exp.push_back(uart_tx_reg[8*i +: 8]);
        tx_start_exp.push_back(cyc + 1);
        busy = 40 * B;
      end
    end
  end

  task automatic decode(output logic [7:0] b, output logic ok, output logic stopv);
    logic [9:0] bits;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bits[i] = uart_tx;
      for (int c = 1; c < B; c++) begin
        @(negedge sys_clk);
        if (uart_tx !== bits[i]) ok = 1'b0;
      end
      @(negedge sys_clk);
    end
    b     = bits[8:1];
    stopv = bits[9];
  endtask

  initial begin
    logic [7:0] b;
    logic       ok, stopv;
    wait (mon_on);
    forever begin
      @(negedge sys_clk);
      if (uart_tx === 1'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (k == 0) begin
            if (tx_start_exp.size() == 0) chk("tx_start_unexpected", 32'(uart_tx), 32'd1);
            else chk("tx_start_latency", cyc, tx_start_exp.pop_front());
          end else begin
            chk("tx_no_gap", 32'(uart_tx), 32'd0);
          end
          decode(b, ok, stopv);
          chk("tx_bit_width", 32'(ok), 32'd1);
          chk("tx_stop_bit", 32'(stopv), 32'd1);
          if (tx_exp.size() == 0) chk("tx_byte_unexpected", 32'(b), 32'hxxxxxxxx);
          else chk("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
          tx_log.push_back(b);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic hold(input logic v, input int n);
    uart_rx = v;
    step(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, B);
    for (int i = 0; i < 8; i++) hold(b[i], B);
    if (stop) model_byte(b);
    hold(stop, B);
    if (!stop) hold(1'b1, B);
  endtask

  task automatic pulse_tx(input logic [31:0] w);
    tb_tx_reg = w;
    tb_tx_en  = 1'b1;
    step(1);
    tb_tx_en  = 1'b0;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      chk("reset_tx", 32'(uart_tx), 32'd1);
      chk("reset_rx_reg", uart_rx_reg, 32'd0);
      chk("reset_ready", 32'(uart_rx_ready), 32'd0);
    end
    step(1);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    step(5);

    // back-to-back word received and echoed straight back out
    loop = 1'b1;
    send_frame(8'h80, 1'b1);
    send_frame(8'h40, 1'b1);
    send_frame(8'hC0, 1'b1);
    send_frame(8'h20, 1'b1);
    step(40 * B + 20);
    chk("word1_literal", uart_rx_reg, 32'h8040C020);
    chk("word1_pulses", ready_pulses, 32'd1);
    chk("loop_tx_count", tx_log.size(), 32'd4);
    if (tx_log.size() >= 4)
      chk("loop_tx_bytes", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h8040C020);
    loop = 1'b0;
    step(2);

    // short low glitch must not count as a byte
    hold(1'b0, 3);
    hold(1'b1, 2 * B);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    step(2 * B);
    chk("glitch_word_literal", uart_rx_reg, 32'h11223344);

    // framing error drops the byte without disturbing the count
    send_frame(8'h55, 1'b0);
    send_frame(8'hA1, 1'b1);
    send_frame(8'hB2, 1'b1);
    send_frame(8'hC3, 1'b1);
    send_frame(8'hD4, 1'b1);
    step(2 * B);
    chk("frame_err_word_literal", uart_rx_reg, 32'hA1B2C3D4);

    // request while busy is ignored
    base = tx_log.size();
    pulse_tx(32'hDEADBEEF);
    step(15 * B);
    pulse_tx(32'h12345678);
    step(30 * B);
    chk("busy_tx_count", tx_log.size() - base, 32'd4);
    if (tx_log.size() >= base + 4)
      chk("busy_tx_bytes", {tx_log[base], tx_log[base+1], tx_log[base+2], tx_log[base+3]}, 32'hDEADBEEF);

    // random concurrent traffic on both directions
    fork
      begin
        for (int n = 0; n < 16; n++) begin
          int r;
          r = $urandom_range(0, 9);
          if (r == 0) begin
            hold(1'b0, 3);
            hold(1'b1, B);
          end else begin
            send_frame(8'($urandom), r != 1);
          end
          hold(1'b1, $urandom_range(0, 3));
        end
      end
      begin
        for (int n = 0; n < 3; n++) begin
          pulse_tx($urandom);
          step($urandom_range(5 * B, 30 * B));
          pulse_tx($urandom);
          step(20 * B);
        end
      end
    join
    step(45 * B);
    chk("rx_words_pending", rx_exp.size(), 32'd0);
    chk("tx_bytes_pending", tx_exp.size(), 32'd0);
    chk("tx_starts_pending", tx_start_exp.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
